// File: rtl/fwrisc_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package fwrisc_mem_arbiter_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fwrisc_mem_arbiter.sv
// Single memory port shared by instruction fetch and the LSU.
// Data has priority unless fetch has been passed over STARVE_LIMIT times in a row.
//
//   state  | meaning
//   IDLE   | no transaction; arbitration happens here
//   BUSY_I | fetch owns the memory port until mready
//   BUSY_D | load/store owns the memory port until mready
module fwrisc_mem_arbiter
  import fwrisc_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              ivalid,
  output logic              iready,
  output logic [31:0]       idata,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dwdata,
  input  logic [3:0]        dwstb,
  input  logic              dwrite,
  input  logic              dvalid,
  output logic              dready,
  output logic [31:0]       drdata,
  output logic [ADDR_W-1:0] maddr,
  output logic [31:0]       mwdata,
  output logic [3:0]        mwstb,
  output logic              mwrite,
  output logic              mvalid,
  input  logic              mready,
  input  logic [31:0]       mrdata,
  output logic              grant_d
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_e              r_state;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic                    r_grant_d;

  logic w_idle;
  logic w_starved;
  logic w_take_d;
  logic w_take_i;

  assign w_idle    = (r_state == IDLE);
  assign w_starved = ivalid && (r_starve_cnt == LIMIT);
  assign w_take_d  = w_idle && dvalid && !w_starved;
  assign w_take_i  = w_idle && ivalid && !w_take_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_grant_d    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take_d) begin
            r_state   <= BUSY_D;
            r_grant_d <= 1'b1;
          end else if (w_take_i) begin
            r_state   <= BUSY_I;
            r_grant_d <= 1'b0;
          end
          // Count only data wins that actually made fetch wait.
          if (!ivalid || w_take_i) begin
            r_starve_cnt <= '0;
          end else if (w_take_d && (r_starve_cnt != LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + STARVE_CNT_W'(1);
          end
        end
        BUSY_I, BUSY_D: begin
          if (mready) begin
            r_state <= IDLE;
            if (!ivalid) r_starve_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    maddr  = '0;
    mwdata = '0;
    mwstb  = '0;
    mwrite = 1'b0;
    mvalid = 1'b0;
    iready = 1'b0;
    dready = 1'b0;
    case (r_state)
      BUSY_I: begin
        maddr  = iaddr;
        mvalid = 1'b1;
        iready = mready;
      end
      BUSY_D: begin
        maddr  = daddr;
        mwdata = dwdata;
        mwstb  = dwstb;
        mwrite = dwrite;
        mvalid = 1'b1;
        dready = mready;
      end
      default: ;
    endcase
  end

  assign idata   = mrdata;
  assign drdata  = mrdata;
  assign grant_d = r_grant_d;

  // Requesters must hold valid for the whole granted transaction.
  a_ivalid_held: assert property (@(posedge clock) disable iff (!reset)
    (r_state == BUSY_I) |-> ivalid);
  a_dvalid_held: assert property (@(posedge clock) disable iff (!reset)
    (r_state == BUSY_D) |-> dvalid);

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Directed bench for fwrisc_mem_arbiter: fetch, store, simultaneous, starvation, reset, stray mready.
module tb_fwrisc_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] iaddr;
  logic        ivalid;
  logic        iready;
  logic [31:0] idata;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwstb;
  logic        dwrite;
  logic        dvalid;
  logic        dready;
  logic [31:0] drdata;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [3:0]  mwstb;
  logic        mwrite;
  logic        mvalid;
  logic        mready;
  logic [31:0] mrdata;
  logic        grant_d;

  int n_tests = 0;
  int n_fail  = 0;

  fwrisc_mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset),
    .iaddr(iaddr), .ivalid(ivalid), .iready(iready), .idata(idata),
    .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite),
    .dvalid(dvalid), .dready(dready), .drdata(drdata),
    .maddr(maddr), .mwdata(mwdata), .mwstb(mwstb), .mwrite(mwrite),
    .mvalid(mvalid), .mready(mready), .mrdata(mrdata), .grant_d(grant_d)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; iaddr = '0; ivalid = 0; daddr = '0; dwdata = '0; dwstb = '0;
    dwrite = 0; dvalid = 0; mready = 0; mrdata = '0;
    #12;
    chk("rst_mvalid", 32'(mvalid), 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_mwrite", 32'(mwrite), 0);
    chk("rst_grant_d", 32'(grant_d), 0);
    chk("rst_readys", {30'd0, iready, dready}, 0);
    @(negedge clock); reset = 1'b1;
    step();

    // Fetch only
    ivalid = 1; iaddr = 32'h8000_0000;
    #1 chk("fetch_idle_mvalid", 32'(mvalid), 0);
    step();
    chk("fetch_mvalid", 32'(mvalid), 1);
    chk("fetch_maddr", maddr, 32'h8000_0000);
    chk("fetch_mwrite", 32'(mwrite), 0);
    chk("fetch_mwstb", 32'(mwstb), 0);
    chk("fetch_grant_d", 32'(grant_d), 0);
    mready = 1; mrdata = 32'h6301_0003;
    #1;
    chk("fetch_iready", 32'(iready), 1);
    chk("fetch_idata", idata, 32'h6301_0003);
    chk("fetch_dready", 32'(dready), 0);
    step();
    mready = 0; ivalid = 0;
    #1;
    chk("fetch_done_mvalid", 32'(mvalid), 0);
    chk("fetch_done_iready", 32'(iready), 0);

    // Store, 2-cycle memory latency
    dvalid = 1; dwrite = 1; daddr = 32'h8000_0010; dwdata = 32'hDEAD_BEEF; dwstb = 4'hF;
    step();
    chk("st_mvalid", 32'(mvalid), 1);
    chk("st_maddr", maddr, 32'h8000_0010);
    chk("st_mwrite", 32'(mwrite), 1);
    chk("st_mwstb", 32'(mwstb), 32'hF);
    chk("st_mwdata", mwdata, 32'hDEAD_BEEF);
    chk("st_grant_d", 32'(grant_d), 1);
    chk("st_dready_early", 32'(dready), 0);
    step();
    chk("st_wait_mvalid", 32'(mvalid), 1);
    mready = 1;
    #1;
    chk("st_dready", 32'(dready), 1);
    chk("st_iready", 32'(iready), 0);
    step();
    mready = 0; dvalid = 0; dwrite = 0; dwstb = 0;
    #1;
    chk("st_done_dready", 32'(dready), 0);
    chk("st_done_mvalid", 32'(mvalid), 0);
    chk("st_grant_held", 32'(grant_d), 1);

    // Simultaneous requests: data first, then fetch
    ivalid = 1; iaddr = 32'h8000_0104; dvalid = 1; daddr = 32'h8000_0020;
    step();
    chk("sim_grant_d", 32'(grant_d), 1);
    chk("sim_maddr_d", maddr, 32'h8000_0020);
    chk("sim_mwrite", 32'(mwrite), 0);
    mready = 1; mrdata = 32'hA5A5_1234;
    #1;
    chk("sim_dready", 32'(dready), 1);
    chk("sim_drdata", drdata, 32'hA5A5_1234);
    chk("sim_iready_d", 32'(iready), 0);
    step();
    mready = 0; dvalid = 0;
    step();
    chk("sim_grant_i", 32'(grant_d), 0);
    chk("sim_maddr_i", maddr, 32'h8000_0104);
    mready = 1; mrdata = 32'h0000_0013;
    #1;
    chk("sim_iready", 32'(iready), 1);
    chk("sim_dready_i", 32'(dready), 0);
    step();
    mready = 0; ivalid = 0;
    step();
    chk("sim_cnt_clear", 32'(dut.r_starve_cnt), 0);

    // Starvation: four data grants, then fetch forced
    ivalid = 1; iaddr = 32'h8000_0200; dvalid = 1; daddr = 32'h8000_0300;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("starve_d%0d_grant", k), 32'(grant_d), 1);
      chk($sformatf("starve_d%0d_maddr", k), maddr, 32'h8000_0300);
      mready = 1;
      #1 chk($sformatf("starve_d%0d_dready", k), 32'(dready), 1);
      step();
      mready = 0;
    end
    chk("starve_cnt_sat", 32'(dut.r_starve_cnt), 4);
    step();
    chk("starve_fetch_grant", 32'(grant_d), 0);
    chk("starve_fetch_maddr", maddr, 32'h8000_0200);
    mready = 1;
    #1;
    chk("starve_iready", 32'(iready), 1);
    chk("starve_dready", 32'(dready), 0);
    step();
    mready = 0; ivalid = 0; dvalid = 0;
    #1 chk("starve_cnt_after", 32'(dut.r_starve_cnt), 0);

    // Async reset mid data transaction
    dvalid = 1; dwrite = 1; daddr = 32'h8000_0040; dwstb = 4'h3;
    step();
    chk("rst_busy_mvalid", 32'(mvalid), 1);
    #2 reset = 0;
    #1;
    chk("rst_async_mvalid", 32'(mvalid), 0);
    chk("rst_async_mwrite", 32'(mwrite), 0);
    mready = 1; dvalid = 0; dwrite = 0; dwstb = 0;
    #1 chk("rst_async_dready", 32'(dready), 0);
    @(negedge clock);
    mready = 0; reset = 1; ivalid = 1; iaddr = 32'h8000_0400;
    step();
    chk("rst_post_mvalid", 32'(mvalid), 1);
    chk("rst_post_maddr", maddr, 32'h8000_0400);
    chk("rst_post_grant", 32'(grant_d), 0);
    mready = 1;
    #1 chk("rst_post_iready", 32'(iready), 1);
    step();
    mready = 0; ivalid = 0;
    step();

    // Stray mready in IDLE
    mready = 1; mrdata = 32'h1111_2222;
    #1;
    chk("stray_readys", {30'd0, iready, dready}, 0);
    step();
    chk("stray_mvalid", 32'(mvalid), 0);
    chk("stray_readys2", {30'd0, iready, dready}, 0);
    mready = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwrisc_mem_arbiter.md
Name: fwrisc_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (iaddr/idata/ivalid/iready) and the data load/store requester.
- Sits between fwrisc_fetch / the LSU and the single-ported system memory.
- Arbitration is data-priority with a bounded fetch-starvation limit.
- One outstanding transaction at a time; the grant is held until the downstream handshake completes.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants while ivalid is pending before fetch is forced to win (1..15).
- ADDR_W, 32: address width.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- iaddr  input  ADDR_W  fetch address (word-aligned by fetch)
- ivalid  input  1  fetch request; held until iready
- iready  output  1  one-cycle pulse: fetch complete, idata valid
- idata  output  32  fetch read data
- daddr  input  ADDR_W  data address
- dwdata  input  32  store data
- dwstb  input  4  byte strobes
- dwrite  input  1  1=store, 0=load
- dvalid  input  1  data request; held until dready
- dready  output  1  one-cycle pulse: data access complete
- drdata  output  32  load data
- maddr  output  ADDR_W  memory address
- mwdata  output  32  memory write data
- mwstb  output  4  memory strobes
- mwrite  output  1  memory write enable
- mvalid  output  1  memory request
- mready  input  1  memory completion pulse
- mrdata  input  32  memory read data
- grant_d  output  1  status: current/last grant was data

Behaviour:
- Reset (reset==0, async): state=IDLE, starve_cnt=0, grant_d=0. mvalid, iready, dready are 0 immediately; maddr/mwdata/mwstb/mwrite are 0.
- FSM states:
  - IDLE -> BUSY_D if dvalid && !(ivalid && starve_cnt==STARVE_LIMIT).
  - IDLE -> BUSY_I if ivalid and the BUSY_D condition is false.
  - IDLE stays if neither request is present.
  - BUSY_I / BUSY_D: mvalid=1; m* fields are muxed combinationally from the granted requester. On mready, return to IDLE.
- Latency:
  - Request seen in IDLE at cycle N -> mvalid at N+1.
  - mready at cycle M -> iready/dready=1 at M (combinational pass-through of mready, gated by state). idata/drdata = mrdata at M.
  - Minimum 2 cycles per transaction (1 IDLE turnaround cycle).
- iready asserts only in BUSY_I; dready only in BUSY_D. Both are never high in the same cycle.
- A store in BUSY_I is impossible: mwrite=0 and mwstb=0 whenever the state is BUSY_I.
- starve_cnt (4-bit):
  - Increments on each IDLE->BUSY_D transition taken while ivalid=1.
  - Clears on IDLE->BUSY_I, or when IDLE is entered/held with ivalid=0.
  - Saturates at STARVE_LIMIT.
- Simultaneous ivalid && dvalid in IDLE with starve_cnt<STARVE_LIMIT: data wins. With starve_cnt==STARVE_LIMIT: fetch wins.
- Requester drops valid while granted: this is a protocol violation. The transaction continues to completion and the ready pulse is still issued. A formal assertion flags it.
- mready while IDLE: ignored; no ready pulse is issued.
- Reset mid-transaction: the transaction is abandoned and mvalid drops asynchronously. After release, arbitration restarts from IDLE.
- grant_d: registered; set on IDLE->BUSY_D, cleared on IDLE->BUSY_I, held otherwise.

Decomposition:
- Package fwrisc_mem_arbiter_pkg:
  - State enum {IDLE, BUSY_I, BUSY_D}.
  - STARVE_CNT_W = 4 constant.
- No sub-module: the FSM plus output mux fits in one module (~150 lines).
- Formal harness: fwrisc_mem_arbiter_formal_test, with `anyconst memory latency 1..3.

Test Plan:
- Fetch-only: ivalid=1, iaddr=0x8000_0000, memory returns 0x63010003 after 1 cycle -> mvalid at cycle 1, maddr=0x8000_0000, iready pulse with idata=0x63010003, dready never 1.
- Store: dvalid=1, dwrite=1, daddr=0x8000_0010, dwdata=0xDEADBEEF, dwstb=0xF -> mwrite=1, mwstb=0xF, mwdata=0xDEADBEEF, single dready pulse, grant_d=1.
- Simultaneous: ivalid=dvalid=1 in IDLE -> data served first (grant_d=1), then fetch on the next arbitration.
- Starvation: dvalid held high continuously, ivalid=1, STARVE_LIMIT=4 -> exactly 4 data transactions, then a fetch grant, then starve_cnt=0.
- Async reset: assert reset=0 mid BUSY_D with mready not yet returned -> mvalid=0 the same cycle, no dready. After release with ivalid=1 -> fresh fetch grant 1 cycle later.
- Stray mready in IDLE with no requests -> iready=dready=0 and the state stays IDLE.
